// File: rtl/mem_responder.sv
// mem_responder: bus-side responder for the CPU memory interface.
// Decodes each access into a ROM window (addresses below RAM_BASE, forwarded
// to an external ROM read port) and an internal RAM window, inserts
// WAIT_STATES wait cycles and acknowledges with a one-cycle ready pulse.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   addr, wdata         CPU address / write data
//   mem_read, mem_write level requests (both high = illegal op)
//   rdata, ready        registered read data and one-cycle acknowledge
//   rom_addr, rom_data  ROM read port (rom_data combinational from rom_addr)
//   bus_err             error flag qualified by ready (only with MEM_RESP_ERR_EN)
//
// Optional feature macro: MEM_RESP_ERR_EN adds the bus_err port and its logic.
module mem_responder #(
  parameter logic [15:0] RAM_BASE    = 16'h0100,
  parameter int unsigned RAM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int unsigned AW        = $clog2(RAM_DEPTH);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ILL} op_e;

  state_e      state_q;
  op_e         op_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [3:0]  cnt_q;
  logic [7:0]  rdata_q;
  logic        ready_q;
  logic [7:0]  rom_addr_q;
  logic [7:0]  mem_q [RAM_DEPTH];

  logic        req_c;
  op_e         live_op_c;
  op_e         acc_op_c;
  logic [15:0] acc_addr_c;
  logic [7:0]  acc_wdata_c;
  logic [15:0] off_c;
  logic        is_rom_c;
  logic        is_ram_c;
  logic        exec_c;
  logic [7:0]  rd_val_c;

  // Request qualification and op classification of the live bus
  always_comb begin
    req_c     = mem_read | mem_write;
    live_op_c = OP_READ;
    if (mem_read && mem_write) live_op_c = OP_ILL;
    else if (mem_write)        live_op_c = OP_WRITE;
  end

  // With zero wait states the access completes on the accept edge itself, so
  // the live bus stands in for the not-yet-latched copy.
  always_comb begin
    acc_addr_c  = addr_q;
    acc_wdata_c = wdata_q;
    acc_op_c    = op_q;
    if (state_q == ST_IDLE) begin
      acc_addr_c  = addr;
      acc_wdata_c = wdata;
      acc_op_c    = live_op_c;
    end
    exec_c = ((state_q == ST_IDLE) && req_c && ZERO_WAIT) ||
             ((state_q == ST_WAIT) && (cnt_q == 4'd1));
  end

  // Address decode and read-data selection
  always_comb begin
    off_c    = acc_addr_c - RAM_BASE;
    is_rom_c = (acc_addr_c < RAM_BASE);
    is_ram_c = !is_rom_c && (off_c < 16'(RAM_DEPTH));
    rd_val_c = 8'h00;
    if (acc_op_c == OP_READ) begin
      if (is_rom_c)      rd_val_c = rom_data;
      else if (is_ram_c) rd_val_c = mem_q[off_c[AW-1:0]];
    end
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      cnt_q      <= 4'd0;
      rdata_q    <= 8'h00;
      ready_q    <= 1'b0;
      rom_addr_q <= 8'h00;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_c) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            op_q       <= live_op_c;
            rom_addr_q <= addr[7:0];
            cnt_q      <= 4'(WAIT_STATES);
            state_q    <= ZERO_WAIT ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_ACK;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (exec_c) begin
        ready_q <= 1'b1;
        if (acc_op_c != OP_WRITE) rdata_q <= rd_val_c;
      end
    end
  end

  // RAM is not reset; a write commits only on its completion edge
  always_ff @(posedge clk) begin
    if (reset_n && exec_c && (acc_op_c == OP_WRITE) && is_ram_c)
      mem_q[off_c[AW-1:0]] <= acc_wdata_c;
  end

`ifdef MEM_RESP_ERR_EN
  logic err_q;
  logic err_val_c;

  // Error: illegal op, unmapped address, or write into ROM
  always_comb begin
    err_val_c = (acc_op_c == OP_ILL) || (!is_rom_c && !is_ram_c) ||
                ((acc_op_c == OP_WRITE) && is_rom_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= exec_c && err_val_c;
  end

  assign bus_err = err_q;
`endif

  // Zero-wait ROM reads need the ROM address on the accept edge itself
  assign rom_addr = (ZERO_WAIT && (state_q == ST_IDLE) && req_c) ? addr[7:0] : rom_addr_q;
  assign rdata    = rdata_q;
  assign ready    = ready_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus-side responder for the CPU memory interface; it answers the CPU's `mem_read`/`mem_write` requests on the 16-bit address / 8-bit data bus. It decodes each access into a ROM window below `RAM_BASE` (forwarded to an external ROM read port) and an internal RAM window. It inserts programmable wait states and acknowledges each access with a one-cycle `ready` pulse. It sits between `cpu_top` and the program ROM, replacing the bench-side RAM model.

## Interface

Parameters:
- `RAM_BASE`, 16'h0100: first RAM address; addresses below it are ROM; must be ≤ 16'h0100.
- `RAM_DEPTH`, 256: number of internal RAM bytes; power of two, 16..4096.
- `WAIT_STATES`, 1: extra cycles inserted before `ready`; 0..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr`  in  16  CPU address bus.
- `wdata`  in  8  CPU write data.
- `mem_read`  in  1  read request, level.
- `mem_write`  in  1  write request, level.
- `rdata`  out  8  registered read data.
- `ready`  out  1  one-cycle access acknowledge.
- `rom_addr`  out  8  ROM read address.
- `rom_data`  in  8  ROM read data, combinational from `rom_addr`.
- `bus_err`  out  1  error flag, qualified by `ready`; present only with `MEM_RESP_ERR_EN`.

## Operation

- The FSM has three states: IDLE, WAIT, ACK.
- **IDLE.** A request is either input high at a rising edge.
  - At that edge the block latches `addr`, `wdata` and the op (read/write/illegal). Illegal means both inputs are high.
  - It loads the wait counter with `WAIT_STATES`, then goes to WAIT, or directly to ACK if `WAIT_STATES` = 0.
- **WAIT.** The counter decrements each edge. At the edge where the counter equals 1, the FSM goes to ACK and performs the access.
  - A read captures data into `rdata`.
  - A write commits to RAM.
- **ACK.** `ready` = 1 for exactly one cycle, then the FSM returns to IDLE unconditionally. A request still asserted in IDLE is a new access; the requester deasserts when it sees `ready`.
- Request inputs are ignored outside IDLE. The latched address and data are used, not the live bus.
- **Decode.**
  - ROM: latched address < `RAM_BASE`.
  - RAM: offset = address − `RAM_BASE`, and offset < `RAM_DEPTH`.
  - Otherwise the access is unmapped.
- **Reads.**
  - ROM: `rdata` ← `rom_data`, with `rom_addr` = latched addr[7:0] held from the accept edge.
  - RAM: `rdata` ← RAM[offset].
  - Unmapped: `rdata` ← 8'h00.
- **Writes.**
  - RAM: RAM[offset] ← latched `wdata`.
  - ROM and unmapped writes are dropped; RAM is unchanged.
- **Illegal op:** no RAM write; `rdata` ← 8'h00.
- `rdata` holds its value until the next read or illegal completion. Writes do not change it.
- **Reset** clears: FSM → IDLE, `ready` = 0, `rdata` = 8'h00, `rom_addr` = 8'h00, `bus_err` = 0, wait counter = 0. RAM contents are not cleared.
- **Reset mid-operation:** the access is aborted and a pending write not yet committed is discarded.

## Timing

- Accept edge E0, then `ready` is high during the cycle after edge E0+`WAIT_STATES`. Latency is `WAIT_STATES`+1 cycles.
- Throughput: one access per `WAIT_STATES`+2 cycles under back-to-back requests.
- `rdata` and `bus_err` are valid in the same cycle as `ready` and are registered (no combinational input→output paths except via `rom_data` capture).
- `rom_addr` is stable from the cycle after E0 through the ACK cycle; the ROM data path budget is `WAIT_STATES`+1 cycles.

## Configuration

- **With `MEM_RESP_ERR_EN` defined:** the `bus_err` port exists and is set with `ready` for any of:
  - a write to ROM,
  - an unmapped access,
  - an illegal op.

  It is 0 with `ready` otherwise and 0 in all other cycles.
- **Without `MEM_RESP_ERR_EN`:** the `bus_err` port and its logic are absent. Data-path behaviour is identical in both builds.

## Test plan

- **RAM round trip.** Defaults. Write 8'h5F to 16'h0100, then read 16'h0100. Required: `ready` 2 cycles after each accept edge, `rdata` = 8'h5F, `bus_err` = 0.
- **ROM read at zero wait.** `WAIT_STATES`=0, ROM model returns 8'hA9 at 8'h00. Read 16'h0000. Required: `rom_addr` = 8'h00, `ready` the cycle after accept, `rdata` = 8'hA9.
- **Dropped writes.** Write 8'h11 to 16'h0005 (ROM) and to 16'h0200 (unmapped, `RAM_DEPTH`=256).
  - Required: later reads return the ROM value and 8'h00 respectively.
  - With `MEM_RESP_ERR_EN`: `bus_err` = 1 on both write acks.
- **Illegal op.** `mem_read` and `mem_write` both high at 16'h0100 holding 8'h33. Required: `rdata` = 8'h00, RAM[0] still 8'h33, `bus_err` = 1 when enabled.
- **Held request / bus change.** `WAIT_STATES`=3. Hold `mem_read` at 16'h0101 across ACK, and change `addr` during WAIT. Required: the data returned is for the latched address; a second access is accepted in the IDLE cycle after ACK; `ready` is never high for two consecutive cycles.
- **Reset mid-write.** Assert `reset_n`=0 during WAIT of a write of 8'h77 to 16'h0102 (previously 8'h00). Required: all outputs at reset values immediately; a subsequent read of 16'h0102 returns 8'h00.
